// File: rtl/tdc_capture_encoder.sv
// TDC front-end sequencer: launches the delay-line pulse, synchronises the tap word
// and accumulates bubble-tolerant popcounts over 2^AVG_LOG2 shots per measurement.
module tdc_capture_encoder #(
  parameter  int N          = 64,
  parameter  int AVG_LOG2   = 0,
  parameter  int CLR_CYCLES = 2,
  localparam int CNT_W      = $clog2(N + 1),
  localparam int RES_W      = CNT_W + AVG_LOG2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             pulse_o,
  input  logic [N-1:0]     meas_i,
  output logic [RES_W-1:0] result_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             bubble_o,
  output logic             sat_o,
  output logic             busy_o
);
  localparam int SHOTS  = 1 << AVG_LOG2;
  localparam int SHOT_W = AVG_LOG2 + 1;
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_CAP, S_ENC, S_CLEAR, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CLR_W-1:0]  clr_cnt;
  logic [SHOT_W-1:0] shot_cnt;
  logic              active;
  logic [RES_W-1:0]  acc;
  logic              bubble_sticky, sat_sticky;
  logic [N-1:0]      sync1, sync2;

  logic              clr_done, more_shots;
  logic [CNT_W-1:0]  pop_shot;
  logic              bubble_shot, sat_shot;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign pop_shot    = popcount(sync2);
  // A 0 directly below a 1 is a bubble; the popcount already corrects for it.
  assign bubble_shot = |(~sync2[N-2:0] & sync2[N-1:1]);
  assign sat_shot    = &sync2;
  assign clr_done    = (clr_cnt == CLR_W'(1));
  assign more_shots  = (shot_cnt < SHOT_W'(SHOTS));
  assign busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_CAP;
      S_CAP:    state_nxt = S_ENC;
      S_ENC:    state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (clr_done) begin
          if (!active)        state_nxt = S_IDLE;
          else if (more_shots) state_nxt = S_LAUNCH;
          else                state_nxt = S_DONE;
        end
      end
      S_DONE:   if (ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_o       <= 1'b0;
      valid_o       <= 1'b0;
      result_o      <= '0;
      bubble_o      <= 1'b0;
      sat_o         <= 1'b0;
      clr_cnt       <= CLR_W'(CLR_CYCLES);
      shot_cnt      <= '0;
      active        <= 1'b0;
      acc           <= '0;
      bubble_sticky <= 1'b0;
      sat_sticky    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            acc           <= '0;
            shot_cnt      <= '0;
            bubble_sticky <= 1'b0;
            sat_sticky    <= 1'b0;
            active        <= 1'b1;
            pulse_o       <= 1'b1;
          end
        end
        S_ENC: begin
          acc           <= acc + RES_W'(pop_shot);
          bubble_sticky <= bubble_sticky | bubble_shot;
          sat_sticky    <= sat_sticky | sat_shot;
          pulse_o       <= 1'b0;
          shot_cnt      <= shot_cnt + SHOT_W'(1);
          clr_cnt       <= CLR_W'(CLR_CYCLES);
        end
        S_CLEAR: begin
          if (!clr_done) begin
            clr_cnt <= clr_cnt - CLR_W'(1);
          end else if (active && more_shots) begin
            pulse_o <= 1'b1;
          end else if (active) begin
            result_o <= acc;
            bubble_o <= bubble_sticky;
            sat_o    <= sat_sticky;
            valid_o  <= 1'b1;
            active   <= 1'b0;
          end
        end
        S_DONE: if (ready_i) valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the synchroniser flops carry no reset; they are overwritten before every use.
  always_ff @(posedge clk_i) begin
    if (state == S_LAUNCH) sync1 <= meas_i;
    if (state == S_CAP)    sync2 <= sync1;
  end

endmodule

// File: doc/tdc_capture_encoder.md
Name: tdc_capture_encoder

Overview:
Sequencer and encoder directly downstream of the TDC delay line. It launches the pulse into the line, captures the asynchronous tap word through a two-flop synchroniser, and encodes the thermometer code to a bubble-tolerant binary count. It can optionally accumulate 2^AVG_LOG2 shots per measurement, flags bubbles and saturation, and presents the result through a valid/ready handshake.

Parameters:
N, 64, number of delay-line taps (width of meas_i).
AVG_LOG2, 0, log2 of shots accumulated per measurement (0..4).
CLR_CYCLES, 2, cycles pulse_o is held low between shots so the line drains (>=1).
CNT_W, $clog2(N+1), derived: per-shot count width (7 for N=64).
RES_W, CNT_W+AVG_LOG2, derived: result width.

Ports:
clk_i  input  1  single clock.
rst_i  input  1  synchronous reset, active-high.
start_i  input  1  measurement request; sampled only in IDLE.
pulse_o  output  1  registered launch pulse to the delay-line input.
meas_i  input  N  asynchronous delay-line taps; bit 0 is the first tap.
result_o  output  RES_W  sum of per-shot popcounts.
valid_o  output  1  result_o and flags are valid.
ready_i  input  1  consumer accepts the result.
bubble_o  output  1  at least one shot was not a pure thermometer code.
sat_o  output  1  at least one shot captured all ones (range overflow).
busy_o  output  1  high in any state except IDLE.

Behaviour:
- FSM states: IDLE, LAUNCH, CAP, ENC, CLEAR, DONE.
- Reset:
  - At any cycle, including mid-measurement, the next state is CLEAR with the clear counter loaded to CLR_CYCLES and the shot counter set to 0.
  - Outputs after reset: pulse_o=0, valid_o=0, result_o=0, bubble_o=0, sat_o=0, busy_o=1.
  - After CLR_CYCLES cycles the FSM enters IDLE, not LAUNCH. The shot-count check applies only to a measurement in progress.
- IDLE:
  - With start_i=1 at an edge: clear the accumulator, shot counter and sticky flags, then go to LAUNCH.
  - Entering LAUNCH sets pulse_o=1 at that edge.
- LAUNCH (1 cycle): go to CAP. The same edge captures sync1<=meas_i.
- CAP (1 cycle): sync2<=sync1; go to ENC.
- ENC (1 cycle), at the exiting edge:
  - acc += popcount(sync2).
  - bubble_sticky |= any i in 0..N-2 with sync2[i]==0 and sync2[i+1]==1.
  - sat_sticky |= (sync2 == all ones).
  - Set pulse_o=0, increment the shot counter, load the clear counter, go to CLEAR.
- CLEAR (CLR_CYCLES cycles, pulse_o=0):
  - If shots < 2^AVG_LOG2, go to LAUNCH (pulse_o=1).
  - Otherwise go to DONE. The entry edge loads result_o=acc, bubble_o and sat_o from the sticky flags, and sets valid_o=1.
- pulse_o timing: high for exactly 3 cycles per shot, and low for at least CLR_CYCLES cycles between shots.
- Latency, AVG_LOG2=0, CLR_CYCLES=2: start_i sampled at edge 0; pulse_o rises at edge 1; valid_o rises at edge 6. In general, valid_o rises at edge 2^AVG_LOG2*(3+CLR_CYCLES)+1.
- DONE:
  - valid_o, result_o, bubble_o and sat_o stay stable while ready_i=0.
  - A handshake (valid_o & ready_i) at an edge gives valid_o=0 and state IDLE.
  - result_o and the flags hold their values until the next DONE entry.
- start_i is ignored outside IDLE; requests are not queued.
- Arithmetic:
  - popcount is CNT_W bits wide.
  - The accumulator is RES_W bits and cannot overflow: max N*2^AVG_LOG2 <= 2^RES_W-1.
  - Bubble correction is implicit: popcount counts all ones regardless of position.
- No combinational path from meas_i to any output. meas_i feeds only sync1.

Test Plan:
- Basic (AVG_LOG2=0, CLR_CYCLES=2): reset, then start_i pulse with meas_i=64'h0000_0000_0000_FFFF held -> pulse_o high at edges 1..3; valid_o=1 from edge 6; result_o=16, bubble_o=0, sat_o=0; busy_o=1 until handshake.
- Bubble: meas_i=64'h0000_0000_0000_00FB -> result_o=7, bubble_o=1, sat_o=0.
- Saturation: meas_i=all ones -> result_o=64, sat_o=1. Next measurement with 64'h3 -> result_o=2, sat_o=0 (flags do not carry across measurements).
- Averaging (AVG_LOG2=2): model returns 10, 11, 12, 13 ones on successive launches -> 4 pulse_o bursts separated by >=2 low cycles; one valid_o; result_o=46.
- Backpressure: ready_i=0 for 5 cycles in DONE while start_i toggles -> result_o/valid_o stable, no new pulse_o. ready_i=1 -> valid_o=0 next cycle, IDLE; a following start_i is accepted.
- Reset mid-op: rst_i asserted in CAP -> next cycle pulse_o=0, valid_o=0, result_o=0, busy_o=1 for 2 cycles, then IDLE. start_i sampled during CLEAR is ignored.
